// File: rtl/riscv_cpu_if.sv
// External pins of riscv_cpu.
// The master side drives bp_enable and serial_in; the slave side drives serial_out.
interface riscv_cpu_if;
  logic bp_enable;
  logic serial_in;
  logic serial_out;

  modport master (
    output bp_enable,
    output serial_in,
    input  serial_out
  );

  modport slave (
    input  bp_enable,
    input  serial_in,
    output serial_out
  );
endinterface

// File: rtl/riscv_cpu.sv
// Multi-cycle RV32I core: FETCH -> EXEC -> [MEM] -> WB, with on-chip
// BIOS/IMEM/DMEM, cycle/instret counters and an 8N1 UART transmitter.
module riscv_cpu #(
  parameter int          CPU_CLOCK_FREQ = 50_000_000,
  parameter logic [31:0] RESET_PC       = 32'h4000_0000,
  parameter int          BAUD_RATE      = 115_200
) (
  input logic        clk,
  input logic        rst,
  riscv_cpu_if.slave io
);
  localparam logic [31:0] BIT_M =
    32'(CPU_CLOCK_FREQ / BAUD_RATE - 1);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, WB} state_t;

  state_t      state;
  logic [31:0] pc, ir, res, sdat, npc, mmio_q;
  logic        wen;
  logic [31:0] rf [32];
  logic [31:0] bios_q, imem_q, dmem_q, inst;
  logic [31:0] cyc_cnt, ins_cnt;
  logic        tx_busy, tx_ready, so;
  logic [8:0]  tsr;
  logic [3:0]  tbit;
  logic [31:0] tcnt;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [31:0] rs1v, rs2v;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign inst  = (pc[31:28] == 4'h4) ? bios_q : imem_q;
  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign rd    = inst[11:7];
  assign rs1v  = (inst[19:15] == 5'd0) ? 32'd0 : rf[inst[19:15]];
  assign rs2v  = (inst[24:20] == 5'd0) ? 32'd0 : rf[inst[24:20]];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'd0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                  inst[20], inst[30:21], 1'b0};

  logic is_lui, is_auipc, is_jal, is_jalr, is_br;
  logic is_ld, is_st, is_op, is_alu, is_sys;

  assign is_lui   = opc == 7'h37;
  assign is_auipc = opc == 7'h17;
  assign is_jal   = opc == 7'h6f;
  assign is_jalr  = opc == 7'h67;
  assign is_br    = opc == 7'h63;
  assign is_ld    = opc == 7'h03;
  assign is_st    = opc == 7'h23;
  assign is_op    = opc == 7'h33;
  assign is_alu   = is_op || opc == 7'h13;
  assign is_sys   = opc == 7'h73;

  logic [31:0] alu_b, alu, sra;
  logic [4:0]  sh;
  logic        taken;

  assign alu_b = is_op ? rs2v : imm_i;
  assign sh    = alu_b[4:0];
  assign sra   = $signed(rs1v) >>> sh;

  always_comb begin
    unique case (f3)
      3'd0: alu = (is_op && inst[30]) ? rs1v - alu_b
                                      : rs1v + alu_b;
      3'd1: alu = rs1v << sh;
      3'd2: alu = {31'd0, $signed(rs1v) < $signed(alu_b)};
      3'd3: alu = {31'd0, rs1v < alu_b};
      3'd4: alu = rs1v ^ alu_b;
      3'd5: alu = inst[30] ? sra : rs1v >> sh;
      3'd6: alu = rs1v | alu_b;
      default: alu = rs1v & alu_b;
    endcase
    unique case (f3)
      3'd0: taken = rs1v == rs2v;
      3'd1: taken = rs1v != rs2v;
      3'd4: taken = $signed(rs1v) < $signed(rs2v);
      3'd5: taken = $signed(rs1v) >= $signed(rs2v);
      3'd6: taken = rs1v < rs2v;
      3'd7: taken = rs1v >= rs2v;
      default: taken = 1'b0;
    endcase
  end

  logic [31:0] x_res, x_npc;
  logic        x_wen, x_mem;

  always_comb begin
    x_res = alu;
    x_npc = pc + 32'd4;
    x_wen = 1'b1;
    x_mem = 1'b0;
    unique case (1'b1)
      is_lui:   x_res = imm_u;
      is_auipc: x_res = pc + imm_u;
      is_jal: begin
        x_res = pc + 32'd4;
        x_npc = pc + imm_j;
      end
      is_jalr: begin
        x_res = pc + 32'd4;
        x_npc = (rs1v + imm_i) & ~32'd1;
      end
      is_br: begin
        x_wen = 1'b0;
        if (taken) x_npc = pc + imm_b;
      end
      is_ld: begin
        x_res = rs1v + imm_i;
        x_mem = 1'b1;
      end
      is_st: begin
        x_res = rs1v + imm_s;
        x_mem = 1'b1;
        x_wen = 1'b0;
      end
      is_alu: x_res = alu;
      // tohost CSR access: accepted, rd gets 0
      is_sys: begin
        x_res = 32'd0;
        x_wen = f3 != 3'd0;
      end
      default: x_wen = 1'b0;
    endcase
  end

  logic        ir_ld, ir_st, st, is_io, tx_go, clr;
  logic [3:0]  be, dmem_we, imem_we;
  logic [31:0] wd, mrd, lw, lsh, ld;

  assign ir_ld = ir[6:0] == 7'h03;
  assign ir_st = ir[6:0] == 7'h23;
  assign st    = state == MEM && ir_st;
  assign is_io = res[31:28] == 4'h8;
  assign tx_go = st && is_io && res[27:0] == 28'h8 && tx_ready;
  assign clr   = st && is_io && res[27:0] == 28'h18;

  always_comb begin
    unique case (ir[13:12])
      2'd0: begin
        be = 4'b0001 << res[1:0];
        wd = {4{sdat[7:0]}};
      end
      2'd1: begin
        be = res[1] ? 4'b1100 : 4'b0011;
        wd = {2{sdat[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = sdat;
      end
    endcase
  end

  assign dmem_we = (st && (res[31:28] == 4'h1 ||
                           res[31:28] == 4'h3)) ? be : 4'd0;
  assign imem_we = (st && res[31:29] == 3'b001 &&
                    pc[31:28] == 4'h4) ? be : 4'd0;

  // ROM image comes with the bitstream; its write port is tied off.
  logic bios_we;
  assign bios_we = 1'b0;

  if (1) begin : bios
    logic [31:0] mem [4096];
    always_ff @(posedge clk) begin
      if (bios_we) mem[res[13:2]] <= sdat;
      bios_q <= mem[(state == FETCH) ? pc[13:2] : res[13:2]];
    end
  end

  if (1) begin : imem
    logic [31:0] mem [16384];
    always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
        if (imem_we[i]) mem[res[15:2]][8*i +: 8] <= wd[8*i +: 8];
      imem_q <= mem[(state == FETCH) ? pc[15:2] : res[15:2]];
    end
  end

  if (1) begin : dmem
    logic [31:0] mem [16384];
    always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
        if (dmem_we[i]) mem[res[15:2]][8*i +: 8] <= wd[8*i +: 8];
      dmem_q <= mem[res[15:2]];
    end
  end

  always_comb begin
    unique case (res[27:0])
      28'h0:   mrd = {31'd0, tx_ready};
      28'h10:  mrd = cyc_cnt;
      28'h14:  mrd = ins_cnt;
      default: mrd = 32'd0;
    endcase
    unique case (res[31:28])
      4'h1:    lw = dmem_q;
      4'h4:    lw = bios_q;
      4'h8:    lw = mmio_q;
      default: lw = 32'd0;
    endcase
    lsh = lw >> {res[1:0], 3'b000};
    unique case (ir[14:12])
      3'd0:    ld = {{24{lsh[7]}}, lsh[7:0]};
      3'd1:    ld = {{16{lsh[15]}}, lsh[15:0]};
      3'd4:    ld = {24'd0, lsh[7:0]};
      3'd5:    ld = {16'd0, lsh[15:0]};
      default: ld = lw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc    <= RESET_PC;
      state <= FETCH;
    end else begin
      unique case (state)
        FETCH: state <= EXEC;
        EXEC: begin
          ir    <= inst;
          res   <= x_res;
          sdat  <= rs2v;
          npc   <= x_npc;
          wen   <= x_wen && rd != 5'd0;
          state <= x_mem ? MEM : WB;
        end
        MEM: begin
          mmio_q <= mrd;
          state  <= WB;
        end
        default: begin
          pc    <= npc;
          state <= FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk)
    if (rst && state == WB && wen)
      rf[ir[11:7]] <= ir_ld ? ld : res;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cyc_cnt <= 32'd0;
      ins_cnt <= 32'd0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (state == WB) ins_cnt <= ins_cnt + 32'd1;
    end
  end

  assign tx_ready      = !tx_busy;
  assign io.serial_out = so;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_busy <= 1'b0;
      so      <= 1'b1;
      tcnt    <= 32'd0;
      tbit    <= 4'd0;
    end else if (tx_go) begin
      tsr     <= {1'b1, sdat[7:0]};
      so      <= 1'b0;
      tcnt    <= 32'd0;
      tbit    <= 4'd0;
      tx_busy <= 1'b1;
    end else if (tx_busy) begin
      if (tcnt == BIT_M) begin
        tcnt <= 32'd0;
        if (tbit == 4'd9) begin
          tx_busy <= 1'b0;
        end else begin
          so   <= tsr[0];
          tsr  <= {1'b1, tsr[8:1]};
          tbit <= tbit + 4'd1;
        end
      end else begin
        tcnt <= tcnt + 32'd1;
      end
    end
  end

  wire unused_ok = &{1'b0, io.bp_enable, io.serial_in,
                     ir[31:15]};
endmodule

// File: tb/tb_riscv_cpu.sv
// Directed bench for riscv_cpu: runs a small imem program and
// decodes the UART line at 5 cycles per bit.
module tb_riscv_cpu;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  riscv_cpu_if io ();

  riscv_cpu #(
    .CPU_CLOCK_FREQ(50_000_000),
    .RESET_PC(BASE),
    .BAUD_RATE(10_000_000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io(io)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] prog [$];
  logic [7:0]  rx_q [$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3,
                                        int rd, logic [6:0] op);
    logic [11:0] v;
    v = 12'(imm);
    return {v, 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1,
                                        int f3);
    logic [11:0] v;
    v = 12'(imm);
    return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(int off, int rs2, int rs1,
                                        int f3);
    logic [12:0] v;
    v = 13'(off);
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3),
            v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(int imm, int rd,
                                        logic [6:0] op);
    return {20'(imm), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1,
                                        int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_j(int off, int rd);
    logic [20:0] v;
    v = 21'(off);
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
  endfunction

  // UART line decoder: start detected at first low negedge,
  // data bits sampled mid-bit.
  initial begin
    logic [7:0] c;
    forever begin
      @(negedge clk);
      if (rst && io.serial_out === 1'b0) begin
        chk("tx_busy_start", 32'(dut.tx_ready), 32'd0);
        for (int k = 1; k < 5; k++) begin
          @(negedge clk);
          chk("start_low", 32'(io.serial_out), 32'd0);
        end
        repeat (3) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
          c[b] = io.serial_out;
          repeat (5) @(negedge clk);
        end
        chk("stop_bit", 32'(io.serial_out), 32'd1);
        chk("tx_busy_stop", 32'(dut.tx_ready), 32'd0);
        rx_q.push_back(c);
      end
    end
  end

  initial begin
    io.bp_enable = 1'b0;
    io.serial_in = 1'b1;

    prog.push_back(enc_i(5, 0, 0, 1, 7'h13));
    prog.push_back(enc_u(32'h10000, 2, 7'h37));
    prog.push_back(enc_s(0, 1, 2, 2));
    prog.push_back(enc_i(16, 2, 0, 3, 7'h03));
    prog.push_back(enc_i(16, 2, 4, 4, 7'h03));
    prog.push_back(enc_i(18, 2, 1, 5, 7'h03));
    prog.push_back(enc_i(32'h12, 0, 0, 6, 7'h13));
    prog.push_back(enc_s(17, 6, 2, 0));
    prog.push_back(enc_u(32'h80000, 7, 7'h37));
    prog.push_back(enc_i(32'h41f, 7, 5, 8, 7'h13));
    prog.push_back(enc_i(1, 0, 0, 9, 7'h13));
    prog.push_back(enc_r(0, 8, 9, 3, 10));
    prog.push_back(enc_i(7, 0, 0, 0, 7'h13));
    prog.push_back(enc_i(1, 0, 0, 11, 7'h13));
    prog.push_back(enc_b(8, 9, 9, 0));
    prog.push_back(enc_i(99, 0, 0, 11, 7'h13));
    prog.push_back(enc_i(1, 0, 0, 14, 7'h13));
    prog.push_back(enc_u(0, 12, 7'h17));
    prog.push_back(enc_i(13, 12, 0, 13, 7'h67));
    prog.push_back(enc_i(99, 0, 0, 14, 7'h13));
    prog.push_back(enc_i(32'h41, 0, 0, 15, 7'h13));
    prog.push_back(enc_s(8, 15, 7, 2));
    prog.push_back(enc_i(32'h42, 0, 0, 16, 7'h13));
    prog.push_back(enc_s(8, 16, 7, 2));
    prog.push_back(enc_i(0, 7, 2, 17, 7'h03));
    prog.push_back(enc_i(1, 17, 7, 17, 7'h13));
    prog.push_back(enc_b(-8, 0, 17, 0));
    prog.push_back(enc_s(8, 16, 7, 2));
    prog.push_back(enc_s(24, 0, 7, 2));
    for (int i = 1; i <= 10; i++)
      prog.push_back(enc_i(i, 0, 0, 20, 7'h13));
    prog.push_back(enc_i(20, 7, 2, 21, 7'h03));
    prog.push_back(enc_i(16, 7, 2, 22, 7'h03));
    prog.push_back(enc_j(0, 0));

    for (int i = 0; i < prog.size(); i++)
      dut.imem.mem[i] = prog[i];
    dut.dmem.mem[4] = 32'h8081_82ff;

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", dut.pc, BASE);
    chk("rst_state", 32'(dut.state), 32'd0);
    chk("rst_serial", 32'(io.serial_out), 32'd1);
    chk("rst_cyc", dut.cyc_cnt, 32'd0);
    chk("rst_ins", dut.ins_cnt, 32'd0);
    chk("rst_ready", 32'(dut.tx_ready), 32'd1);
    rst = 1'b1;

    @(negedge clk);
    chk("fetch0", dut.inst, prog[0]);
    repeat (2) @(negedge clk);
    chk("cpi3_x1", dut.rf[1], 32'd5);
    chk("cpi3_pc", dut.pc, BASE + 32'd4);
    repeat (7) @(negedge clk);
    chk("cpi4_pc", dut.pc, BASE + 32'd12);
    chk("sw_dmem0", dut.dmem.mem[0], 32'd5);

    repeat (800) @(negedge clk);
    chk("lb", dut.rf[3], 32'hffff_ffff);
    chk("lbu", dut.rf[4], 32'h0000_00ff);
    chk("lh", dut.rf[5], 32'hffff_8081);
    chk("sb", dut.dmem.mem[4], 32'h8081_12ff);
    chk("srai", dut.rf[8], 32'hffff_ffff);
    chk("sltu", dut.rf[10], 32'd1);
    chk("x0_beq", dut.rf[11], 32'd1);
    chk("auipc", dut.rf[12], BASE + 32'h44);
    chk("jalr_rd", dut.rf[13], BASE + 32'h4c);
    chk("jalr_skip", dut.rf[14], 32'd1);
    chk("poll", dut.rf[17], 32'd1);
    chk("addi10", dut.rf[20], 32'd10);
    // SW's own WB lands after the clear, plus 10 ADDIs
    chk("instret", dut.rf[21], 32'd11);
    // 1 (SW WB) + 30 (ADDIs) + 4 (LW) + 2 (next LW to MEM)
    chk("cycles", dut.rf[22], 32'd37);
    chk("spin_pc", dut.pc, BASE + 32'ha4);
    chk("rx_count", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() >= 1) chk("rx_0", 32'(rx_q[0]), 32'h41);
    if (rx_q.size() >= 2) chk("rx_1", 32'(rx_q[1]), 32'h42);

    rst = 1'b0;
    @(negedge clk);
    chk("pulse_cyc", dut.cyc_cnt, 32'd0);
    chk("pulse_ins", dut.ins_cnt, 32'd0);
    chk("pulse_pc", dut.pc, BASE);
    chk("pulse_serial", 32'(io.serial_out), 32'd1);
    chk("pulse_keep_x1", dut.rf[1], 32'd5);
    rst = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/riscv_cpu.md
Name: riscv_cpu

Overview:
- Multi-cycle, in-order RV32I integer CPU with internal BIOS, instruction and data memories, and a memory-mapped 8N1 UART transmitter with cycle/instruction counters.
- Top-level compute block of the FPGA project; the only external I/O is the serial line.
- Floating-point programs run as RV32I code using software floating point. No F extension is implemented.

Parameters:
- CPU_CLOCK_FREQ, 50_000_000: core clock frequency in Hz.
- RESET_PC, 32'h4000_0000: PC loaded on reset.
- BAUD_RATE, 115_200: UART bit rate. Bit period is CPU_CLOCK_FREQ/BAUD_RATE cycles, integer-truncated.

Ports:
- clk  in  1  core clock, all state on the rising edge.
- rst  in  1  reset, synchronous and active-low.
- bp_enable  in  1  branch-predictor enable. Ignored by this design.
- serial_in  in  1  UART receive line. Unused; the receiver is out of scope.
- serial_out  out  1  UART transmit line, idle high.

Behaviour:
- Reset (rst=0 at a clock edge):
  - PC=RESET_PC; FSM=FETCH.
  - serial_out=1, UART idle.
  - Both counters = 0.
  - Register and memory contents are preserved.
- Memories:
  - Word-addressed 32-bit arrays, each named mem, synchronous 1-cycle read.
  - bios: 4096 words.
  - imem: 16384 words.
  - dmem: 16384 words, with per-byte write enables.
- Instruction fetch:
  - PC[31:28]=4'h4 fetches from bios; 4'h1 fetches from imem.
  - Index is PC[13:2] for bios and PC[15:2] for imem.
- FSM and CPI:
  - FETCH: issue address. EXEC: decode, read registers, ALU, branch resolve. MEM: loads and stores only. WB: write rd, update PC.
  - CPI is 3 for non-memory ops and 4 for loads and stores.
- ISA:
  - Full RV32I: LUI, AUIPC, JAL, JALR, branches, LB/LH/LW/LBU/LHU, SB/SH/SW, OP-IMM, OP.
  - CSRRW/CSRRWI to CSR 0x51E is accepted as a no-op writing rd=0 (tohost).
  - FENCE and ECALL are treated as NOPs.
  - x0 is hardwired to 0.
  - JALR clears bit 0 of the target.
  - Shifts use operand[4:0]; SRA/SRAI sign-fill.
  - Unaligned accesses are not trapped: the address is truncated to a word, and the lane is selected by addr[1:0].
- Data map, decoded by addr[31:28]:
  - 4'b0001 (0x1xxx_xxxx): dmem read/write.
  - 4'b0100: bios read.
  - 4'b001x: imem write, performed only while PC[31:28]=4'h4. A write to 4'b0011 also writes dmem.
  - 4'h8: MMIO.
  - Reads of unmapped addresses return 0. Writes to unmapped addresses are dropped.
- MMIO:
  - 0x8000_0000 R: bit0 = tx_ready, bit1 = rx_valid, which always reads 0.
  - 0x8000_0004 R: rx data, always reads 0.
  - 0x8000_0008 W: tx data [7:0]. Accepted only when tx_ready=1; otherwise the write is dropped.
  - 0x8000_0010 R: cycle counter.
  - 0x8000_0014 R: retired-instruction counter.
  - 0x8000_0018 W: any value clears both counters.
- Counters:
  - 32-bit, wrap at 2^32.
  - Cycle counter increments every cycle.
  - Instruction counter increments on each WB.
  - A clear in the same cycle as an increment wins (result 0).
- UART TX:
  - Frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts one bit period.
  - tx_ready=0 from the accepting edge until the stop bit ends.
  - Back-to-back sends are allowed from the next cycle after ready.
  - Reset mid-frame forces idle (serial_out=1) immediately on that edge.

Test Plan:
- Hold rst=0 for 10 cycles, then release with RESET_PC=0x1000_0000 and imem[0]=ADDI x1,x0,5; imem[1]=SW x1,0(x0)+0x1000_0000 base -> dmem.mem[0]=5; first fetch from imem index 0.
- With CPU_CLOCK_FREQ=50e6 and BAUD_RATE=10e6, store 0x41 to 0x8000_0008 -> serial_out goes low for 5 cycles, then 1,0,0,0,0,0,1,0, then stop 1; tx_ready=0 during the frame.
- Store 0x42 while busy, then poll status and send -> only the first character appears until bit0=1; the line carries exactly "AB".
- Loads: dmem word 0x8081_82FF; LB addr+0 -> 0xFFFF_FFFF; LBU -> 0x0000_00FF; LH +2 -> 0xFFFF_8081; SB 0x12 at +1 -> word 0x8081_12FF.
- Arithmetic and control:
  - SRA of 0x8000_0000 by 31 -> 0xFFFF_FFFF.
  - SLTU 1<0xFFFF_FFFF -> 1.
  - BEQ taken: PC+offset.
  - JALR to odd target: low bit cleared, rd=PC+4.
  - Writes to x0 leave x0=0.
- Counters: store to 0x8000_0018, then execute 10 non-memory instructions -> instruction counter=10 and cycle counter=30 (±MMIO access cycles); pulsing rst zeroes both.
